count_watch: RTL and testbench
==============================

COUNT_WATCH -- requirements
Module: count_watch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: width of the monitored count and of the compare value.
REQ-002 The block SHALL have parameter OVR_W, default 8: width of the saturating overrun counter.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port count, input, WIDTH bits: value from the upstream counter, sampled every clock.
REQ-006 The block SHALL have port cmp_val, input, WIDTH bits: compare value, latched on arm.
REQ-007 The block SHALL have port arm, input, 1 bit: request to start watching.
REQ-008 The block SHALL have port clear, input, 1 bit: return to idle and clear all sticky status.
REQ-009 The block SHALL have port match_pulse, output, 1 bit: one-cycle pulse on the first match event.
REQ-010 The block SHALL have port match_flag, output, 1 bit: sticky; high while in HIT.
REQ-011 The block SHALL have port armed, output, 1 bit: high while in ARMED.
REQ-012 The block SHALL have port capture, output, WIDTH bits: count value at the first match event.
REQ-013 The block SHALL have port wrap_seen, output, 1 bit: sticky; count decreased between consecutive samples.
REQ-014 The block SHALL have port overrun, output, OVR_W bits: number of match events while in HIT, saturating.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ARMED and HIT.
REQ-016 In IDLE with arm=1 and clear=0, the FSM SHALL go to ARMED, latch cmp_q<=cmp_val and force eq_q<=0.
REQ-017 Register eq_q SHALL be updated every clock with (count==cmp_q), except when forced to 0 on arm.
REQ-018 A match event SHALL be (count==cmp_q) && !eq_q, evaluated only in ARMED or HIT; a count held at cmp_q SHALL yield one event.
REQ-019 On a match event in ARMED, the FSM SHALL go to HIT; next cycle match_pulse=1 for exactly one cycle, match_flag=1 and capture=count as sampled.
REQ-020 Latency from the count==cmp_q sample edge to match_pulse/match_flag SHALL be one clock, with all outputs registered.
REQ-021 On each match event in HIT, overrun SHALL increment, saturate at all-ones, and SHALL NOT change capture or pulse match_pulse.
REQ-022 arm in ARMED or HIT SHALL be ignored; cmp_val changes after arm SHALL have no effect until the next arm from IDLE.
REQ-023 clear=1 in any state SHALL go to IDLE next cycle and zero match_flag, overrun, wrap_seen and capture; clear SHALL win over a simultaneous arm or match event.
REQ-024 Register prev_count SHALL hold the last count sample; prev_valid SHALL go to 1 after the first sample following reset.
REQ-025 wrap_seen SHALL be set when prev_valid=1 and count<prev_count, unsigned, in any state, and SHALL stay set until clear or reset.
REQ-026 A match event and a wrap in the same cycle SHALL both take effect.

Reset
REQ-027 rst=0 SHALL immediately, without a clock, force: state=IDLE, armed=0, match_pulse=0, match_flag=0, capture=0, wrap_seen=0, overrun=0, cmp_q=0, eq_q=0, prev_count=0, prev_valid=0.
REQ-028 Reset asserted mid-operation SHALL abandon any pending event; after deassertion the block SHALL stay in IDLE until arm.

Configuration
REQ-029 With macro COUNT_WATCH_CAPTURE_EN defined, the capture register SHALL be implemented as REQ-019 and REQ-023 specify.
REQ-030 Without COUNT_WATCH_CAPTURE_EN, capture SHALL be constant 0, no capture flops SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-031 The bench SHALL cover basic match: reset, arm with cmp_val=5, count 0..9 one per clock -> one match_pulse the cycle after count=5, match_flag=1, capture=5, overrun=0.
REQ-032 The bench SHALL cover hold and repeat: with cmp 3 and count 2,3,3,3,4,3 -> one pulse on the first 3, overrun=1 from the later 3.
REQ-033 The bench SHALL cover wrap: count 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0 -> wrap_seen=1 after 0 is sampled and stays 1; nothing is set on the first sample after reset.
REQ-034 The bench SHALL cover clear priority: in HIT, drive clear=1 and arm=1 together with count==cmp -> IDLE, all sticky status 0, no pulse.
REQ-035 The bench SHALL cover asynchronous reset: rst=0 between clock edges while in HIT -> outputs zero before the next edge; rst=1 -> IDLE held until arm.
REQ-036 The bench SHALL cover saturation and config: more than 255 match events with OVR_W=8 -> overrun holds 8'hFF; without COUNT_WATCH_CAPTURE_EN, capture stays 0 throughout.

Source files
------------

// File: rtl/count_watch.sv
// Count watcher: fires a one-cycle pulse when a free-running count first equals a latched compare value.
// Optional capture register enabled by defining COUNT_WATCH_CAPTURE_EN.
module count_watch #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OVR_W = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             arm,
    input  logic             clear,
    output logic             match_pulse,
    output logic             match_flag,
    output logic             armed,
    output logic [WIDTH-1:0] capture,
    output logic             wrap_seen,
    output logic [OVR_W-1:0] overrun
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HIT} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_cmp;
    logic [WIDTH-1:0] r_prev;
    logic             r_eq;
    logic             r_prev_valid;
    logic             r_pulse;
    logic             r_flag;
    logic             r_armed;
    logic             r_wrap;
    logic [OVR_W-1:0] r_ovr;
    logic             w_eq;
    logic             w_event;
    logic             w_arm_go;
    logic             w_wrap;

    // A held count yields one event: r_eq remembers the previous sample already matched.
    assign w_eq     = (count == r_cmp);
    assign w_event  = w_eq && !r_eq && (r_state != S_IDLE);
    assign w_arm_go = (r_state == S_IDLE) && arm && !clear;
    assign w_wrap   = r_prev_valid && (count < r_prev);

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (arm) w_next = S_ARMED;
                S_ARMED: if (w_event) w_next = S_HIT;
                S_HIT:   w_next = S_HIT;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_flag  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_flag  <= (w_next == S_HIT);
            r_armed <= (w_next == S_ARMED);
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_cmp        <= '0;
            r_eq         <= 1'b0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_pulse      <= 1'b0;
            r_wrap       <= 1'b0;
            r_ovr        <= '0;
        end else begin
            r_prev       <= count;
            r_prev_valid <= 1'b1;
            r_eq         <= w_arm_go ? 1'b0 : w_eq;
            if (w_arm_go) begin
                r_cmp <= cmp_val;
            end
            r_pulse <= !clear && (r_state == S_ARMED) && w_event;
            if (clear) begin
                r_wrap <= 1'b0;
                r_ovr  <= '0;
            end else begin
                if (w_wrap) begin
                    r_wrap <= 1'b1;
                end
                if ((r_state == S_HIT) && w_event && (r_ovr != '1)) begin
                    r_ovr <= r_ovr + {{(OVR_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

`ifdef COUNT_WATCH_CAPTURE_EN
    logic [WIDTH-1:0] r_capture;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_capture <= '0;
        end else if (clear) begin
            r_capture <= '0;
        end else if ((r_state == S_ARMED) && w_event) begin
            r_capture <= count;
        end
    end

    assign capture = r_capture;
`else
    assign capture = '0;
`endif

    assign match_pulse = r_pulse;
    assign match_flag  = r_flag;
    assign armed       = r_armed;
    assign wrap_seen   = r_wrap;
    assign overrun     = r_ovr;

endmodule

// File: tb/tb_count_watch.sv
// Self-checking bench for count_watch: directed scenarios plus randomized traffic against a behavioural model.
// Capture expectations follow COUNT_WATCH_CAPTURE_EN.
module tb_count_watch;

    logic        clock;
    logic        rst;
    logic [31:0] count;
    logic [31:0] cmp_val;
    logic        arm;
    logic        clear;
    logic        match_pulse;
    logic        match_flag;
    logic        armed;
    logic [31:0] capture;
    logic        wrap_seen;
    logic [7:0]  overrun;

    int total = 0;
    int bad   = 0;

    count_watch #(.WIDTH(32), .OVR_W(8)) dut (
        .clock       (clock),
        .rst         (rst),
        .count       (count),
        .cmp_val     (cmp_val),
        .arm         (arm),
        .clear       (clear),
        .match_pulse (match_pulse),
        .match_flag  (match_flag),
        .armed       (armed),
        .capture     (capture),
        .wrap_seen   (wrap_seen),
        .overrun     (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: watching/hit flags, sticky status, and the last observed sample.
    logic        m_watch, m_hit, m_pulse, m_wrap, m_have_prev, m_last_eq;
    logic [7:0]  m_ovr;
    logic [31:0] m_cap, m_cmp, m_prev;

    task automatic model_reset();
        m_watch = 0; m_hit = 0; m_pulse = 0; m_wrap = 0;
        m_have_prev = 0; m_last_eq = 0;
        m_ovr = 0; m_cap = 0; m_cmp = 0; m_prev = 0;
    endtask

    task automatic model_step(input logic [31:0] c, input logic a, input logic cl,
                              input logic [31:0] cv);
        logic idle, ev, wr, new_eq;
        idle   = !m_watch && !m_hit;
        ev     = !idle && (c == m_cmp) && !m_last_eq;
        wr     = m_have_prev && (c < m_prev);
        new_eq = (idle && a && !cl) ? 1'b0 : (c == m_cmp);
        if (cl) begin
            m_watch = 0; m_hit = 0; m_pulse = 0;
            m_cap = 0; m_ovr = 0; m_wrap = 0;
        end else begin
            m_pulse = m_watch && ev;
            if (m_watch && ev) begin
                m_watch = 0; m_hit = 1; m_cap = c;
            end else if (m_hit && ev) begin
                if (m_ovr != 8'hFF) m_ovr = m_ovr + 8'd1;
            end else if (idle && a) begin
                m_watch = 1; m_cmp = cv;
            end
            if (wr) m_wrap = 1;
        end
        m_last_eq   = new_eq;
        m_prev      = c;
        m_have_prev = 1;
    endtask

    function automatic logic [43:0] exp_vec();
        logic [31:0] cap;
`ifdef COUNT_WATCH_CAPTURE_EN
        cap = m_cap;
`else
        cap = 32'd0;
`endif
        return {m_pulse, m_hit, m_watch, m_wrap, m_ovr, cap};
    endfunction

    function automatic logic [43:0] obs_vec();
        return {match_pulse, match_flag, armed, wrap_seen, overrun, capture};
    endfunction

    // Drive one clock of stimulus (called just after a rising edge), advance model, settle past edge.
    task automatic tick(input logic [31:0] c, input logic a, input logic cl, input logic [31:0] cv);
        count = c; arm = a; clear = cl; cmp_val = cv;
        model_step(c, a, cl, cv);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        count = 0; arm = 0; clear = 0; cmp_val = 0;
        rst = 1'b0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (obs_vec() !== 44'd0) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", obs_vec(), 44'd0);
        end
        tick(32'd9, 1'b0, 1'b0, 32'd9);
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_idle got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_basic_match();
        do_reset();
        tick(32'd0, 1'b1, 1'b0, 32'd5);
        for (int i = 0; i < 10; i++) begin
            tick(32'(i), 1'b0, 1'b0, 32'd77);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL basic_cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            total++;
            if (match_pulse !== (i == 5)) begin
                bad++;
                $display("FAIL basic_pulse_cyc%0d got=%b exp=%b", i, match_pulse, (i == 5));
            end
        end
        total++;
        if (match_flag !== 1'b1 || overrun !== 8'd0) begin
            bad++;
            $display("FAIL basic_final flag=%b ovr=%0d exp flag=1 ovr=0", match_flag, overrun);
        end
    endtask

    task automatic test_hold_repeat();
        logic [31:0] seq [6];
        int pulses;
        seq = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd4, 32'd3};
        pulses = 0;
        do_reset();
        tick(32'd0, 1'b1, 1'b0, 32'd3);
        for (int i = 0; i < 6; i++) begin
            tick(seq[i], 1'b0, 1'b0, 32'd0);
            if (match_pulse === 1'b1) pulses++;
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL hold_cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        total++;
        if (pulses != 1 || overrun !== 8'd1) begin
            bad++;
            $display("FAIL hold_summary pulses=%0d ovr=%0d exp pulses=1 ovr=1", pulses, overrun);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] seq [4];
        seq = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(seq[i], 1'b0, 1'b0, 32'd0);
            total++;
            if (wrap_seen !== (i >= 2)) begin
                bad++;
                $display("FAIL wrap_cyc%0d got=%b exp=%b", i, wrap_seen, (i >= 2));
            end
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL wrap_vec%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clear_priority();
        logic [31:0] seq [4];
        seq = '{32'd3, 32'd4, 32'd3, 32'd4};
        do_reset();
        tick(32'd0, 1'b1, 1'b0, 32'd3);
        for (int i = 0; i < 4; i++) tick(seq[i], 1'b0, 1'b0, 32'd0);
        total++;
        if (match_flag !== 1'b1 || overrun !== 8'd1) begin
            bad++;
            $display("FAIL clr_setup flag=%b ovr=%0d exp flag=1 ovr=1", match_flag, overrun);
        end
        tick(32'd3, 1'b1, 1'b1, 32'd3);
        total++;
        if (obs_vec() !== 44'd0) begin
            bad++;
            $display("FAIL clr_priority got=%h exp=%h", obs_vec(), 44'd0);
        end
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL clr_model got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(32'd0, 1'b1, 1'b0, 32'd3);
        tick(32'd1, 1'b0, 1'b0, 32'd0);
        tick(32'd3, 1'b0, 1'b0, 32'd0);
        tick(32'd0, 1'b0, 1'b0, 32'd0);
        total++;
        if (match_flag !== 1'b1 || wrap_seen !== 1'b1) begin
            bad++;
            $display("FAIL areset_setup flag=%b wrap=%b exp 1 1", match_flag, wrap_seen);
        end
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs_vec() !== 44'd0) begin
            bad++;
            $display("FAIL areset_immediate got=%h exp=%h", obs_vec(), 44'd0);
        end
        @(posedge clock);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(32'd3, 1'b0, 1'b0, 32'd3);
            total++;
            if (obs_vec() !== exp_vec() || armed !== 1'b0) begin
                bad++;
                $display("FAIL areset_idle%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        tick(32'd3, 1'b1, 1'b0, 32'd3);
        total++;
        if (armed !== 1'b1) begin
            bad++;
            $display("FAIL areset_rearm got=%b exp=1", armed);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] exp_cap;
`ifdef COUNT_WATCH_CAPTURE_EN
        exp_cap = 32'd7;
`else
        exp_cap = 32'd0;
`endif
        do_reset();
        tick(32'd0, 1'b1, 1'b0, 32'd7);
        for (int i = 0; i < 270; i++) begin
            tick(32'd7, 1'b0, 1'b0, 32'd0);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL sat_hi%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            tick(32'd0, 1'b0, 1'b0, 32'd0);
        end
        total++;
        if (overrun !== 8'hFF) begin
            bad++;
            $display("FAIL sat_overrun got=%h exp=ff", overrun);
        end
        total++;
        if (capture !== exp_cap) begin
            bad++;
            $display("FAIL sat_capture got=%h exp=%h", capture, exp_cap);
        end
    endtask

    task automatic test_random();
        logic [31:0] c, cv;
        logic a, cl;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            c  = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 5));
            cv = 32'($urandom_range(0, 5));
            a  = ($urandom_range(0, 99) < 15);
            cl = ($urandom_range(0, 99) < 4);
            tick(c, a, cl, cv);
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rand_cyc%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        count = 0; arm = 0; clear = 0; cmp_val = 0;
        model_reset();
        #1;
        test_reset();
        test_basic_match();
        test_hold_repeat();
        test_wrap();
        test_clear_priority();
        test_async_reset();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
